// File: rtl/aes_ctrl_pkg.sv
// Shared types and encodings for the AES-128 decryption sequencer.
// Holds the FSM state enum, the state-register mux select codes and the round count.
package aes_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_KEYEXP    = 4'd1,
    ST_LOAD      = 4'd2,
    ST_ARK_INIT  = 4'd3,
    ST_INV_SHIFT = 4'd4,
    ST_INV_SUB   = 4'd5,
    ST_ARK       = 4'd6,
    ST_INV_MIX   = 4'd7,
    ST_F_SHIFT   = 4'd8,
    ST_F_SUB     = 4'd9,
    ST_F_ARK     = 4'd10,
    ST_DONE      = 4'd11
  } state_e;

  localparam logic [2:0] SEL_MSG = 3'd0;
  localparam logic [2:0] SEL_ISR = 3'd1;
  localparam logic [2:0] SEL_ISB = 3'd2;
  localparam logic [2:0] SEL_ARK = 3'd3;
  localparam logic [2:0] SEL_IMC = 3'd4;

  localparam int NUM_ROUNDS = 10;

  // Every state between accepting Start and reaching DONE counts as busy.
  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/aes_decrypt_controller.sv
// Sequencing FSM for AES-128 decryption: key-expansion wait, initial AddRoundKey,
// nine inverse rounds and the final round, with registered Moore outputs.
module aes_decrypt_controller
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned KEYEXP_CYCLES = 12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       KEYEXP_EN,
  output logic       STATE_LD,
  output logic [2:0] STATE_SEL,
  output logic [1:0] MIX_WORD,
  output logic [3:0] KEY_IDX,
  output logic       MSG_DEC_LD
);

  localparam logic [7:0] WAIT_INIT = 8'(KEYEXP_CYCLES - 1);
  localparam logic [3:0] KEY_FIRST = 4'(NUM_ROUNDS);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] word_q, word_d;

  logic       busy_d, done_d, kx_d, ld_d, msg_d;
  logic [2:0] sel_d;
  logic [1:0] mix_d;
  logic [3:0] key_d;

  // Next-state and counter update; a low Start in any busy state aborts to IDLE.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rnd_d   = rnd_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (AES_START) begin
          state_d = ST_KEYEXP;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KEYEXP: begin
        if (wait_q == 8'd0) begin
          state_d = ST_LOAD;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_LOAD:      state_d = ST_ARK_INIT;
      ST_ARK_INIT: begin
        state_d = ST_INV_SHIFT;
        rnd_d   = 4'd9;
      end
      ST_INV_SHIFT: state_d = ST_INV_SUB;
      ST_INV_SUB:   state_d = ST_ARK;
      ST_ARK: begin
        state_d = ST_INV_MIX;
        word_d  = 2'd0;
      end
      ST_INV_MIX: begin
        word_d = word_q + 2'd1;
        if (word_q == 2'd3) begin
          if (rnd_q == 4'd1) begin
            state_d = ST_F_SHIFT;
          end else begin
            state_d = ST_INV_SHIFT;
            rnd_d   = rnd_q - 4'd1;
          end
        end else begin
          state_d = ST_INV_MIX;
        end
      end
      ST_F_SHIFT:   state_d = ST_F_SUB;
      ST_F_SUB:     state_d = ST_F_ARK;
      ST_F_ARK:     state_d = ST_DONE;
      ST_DONE: begin
        if (!AES_START) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase

    if (is_busy(state_q) && !AES_START) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end

    if (state_d == ST_IDLE) begin
      wait_d = 8'd0;
      rnd_d  = 4'd0;
      word_d = 2'd0;
    end else begin
      wait_d = wait_d;
    end
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
    kx_d   = (state_d == ST_KEYEXP);
    ld_d   = 1'b0;
    sel_d  = SEL_MSG;
    mix_d  = 2'd0;
    key_d  = 4'd0;
    msg_d  = 1'b0;
    case (state_d)
      ST_LOAD: begin
        ld_d  = 1'b1;
        sel_d = SEL_MSG;
      end
      ST_ARK_INIT: begin
        ld_d  = 1'b1;
        sel_d = SEL_ARK;
        key_d = KEY_FIRST;
      end
      ST_INV_SHIFT, ST_F_SHIFT: begin
        ld_d  = 1'b1;
        sel_d = SEL_ISR;
      end
      ST_INV_SUB, ST_F_SUB: begin
        ld_d  = 1'b1;
        sel_d = SEL_ISB;
      end
      ST_ARK: begin
        ld_d  = 1'b1;
        sel_d = SEL_ARK;
        key_d = rnd_d;
      end
      ST_INV_MIX: begin
        ld_d  = 1'b1;
        sel_d = SEL_IMC;
        mix_d = word_d;
      end
      ST_F_ARK: begin
        ld_d  = 1'b1;
        sel_d = SEL_ARK;
        key_d = 4'd0;
        msg_d = 1'b1;
      end
      default: begin
        ld_d  = 1'b0;
        sel_d = SEL_MSG;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      wait_q     <= 8'd0;
      rnd_q      <= 4'd0;
      word_q     <= 2'd0;
      AES_DONE   <= 1'b0;
      BUSY       <= 1'b0;
      KEYEXP_EN  <= 1'b0;
      STATE_LD   <= 1'b0;
      STATE_SEL  <= 3'd0;
      MIX_WORD   <= 2'd0;
      KEY_IDX    <= 4'd0;
      MSG_DEC_LD <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rnd_q      <= rnd_d;
      word_q     <= word_d;
      AES_DONE   <= done_d;
      BUSY       <= busy_d;
      KEYEXP_EN  <= kx_d;
      STATE_LD   <= ld_d;
      STATE_SEL  <= sel_d;
      MIX_WORD   <= mix_d;
      KEY_IDX    <= key_d;
      MSG_DEC_LD <= msg_d;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_controller.sv
// Self-checking bench for aes_decrypt_controller: three instances (K = 12, 1, 255)
// compared cycle by cycle against a schedule computed from the cycle-numbering rules.
module tb_aes_decrypt_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_r;

  wire [2:0]  done_w, busy_w, kx_w, ld_w, msg_w;
  wire [8:0]  sel_w;
  wire [5:0]  mix_w;
  wire [11:0] key_w;

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned KV = (g == 0) ? 12 : ((g == 1) ? 1 : 255);
    aes_decrypt_controller #(.KEYEXP_CYCLES(KV)) u_dut (
      .CLK       (clk),
      .RESET     (rst_n),
      .AES_START (start_r[g]),
      .AES_DONE  (done_w[g]),
      .BUSY      (busy_w[g]),
      .KEYEXP_EN (kx_w[g]),
      .STATE_LD  (ld_w[g]),
      .STATE_SEL (sel_w[g*3 +: 3]),
      .MIX_WORD  (mix_w[g*2 +: 2]),
      .KEY_IDX   (key_w[g*4 +: 4]),
      .MSG_DEC_LD(msg_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: busy, done, keyexp_en, state_ld, sel[3], mix[2], key[4], msg_ld
  function automatic logic [13:0] obs(input int i);
    return {busy_w[i], done_w[i], kx_w[i], ld_w[i], sel_w[i*3 +: 3],
            mix_w[i*2 +: 2], key_w[i*4 +: 4], msg_w[i]};
  endfunction

  // Expected outputs in cycle c of a run with Start held high, cycle 1 = first KEYEXP cycle.
  function automatic logic [13:0] model(input int k, input int c);
    logic b, d, kx, ld, msg;
    int sel, mw, key, off, ph;
    b = 1'b0; d = 1'b0; kx = 1'b0; ld = 1'b0; msg = 1'b0;
    sel = 0; mw = 0; key = 0;
    if (c >= 1 && c <= k) begin
      b = 1'b1; kx = 1'b1;
    end else if (c == k + 1) begin
      b = 1'b1; ld = 1'b1; sel = 0;
    end else if (c == k + 2) begin
      b = 1'b1; ld = 1'b1; sel = 3; key = 10;
    end else if (c >= k + 3 && c <= k + 65) begin
      off = c - (k + 3);
      ph  = off % 7;
      b = 1'b1; ld = 1'b1;
      if (ph == 0) sel = 1;
      else if (ph == 1) sel = 2;
      else if (ph == 2) begin sel = 3; key = 9 - off / 7; end
      else begin sel = 4; mw = ph - 3; end
    end else if (c == k + 66) begin
      b = 1'b1; ld = 1'b1; sel = 1;
    end else if (c == k + 67) begin
      b = 1'b1; ld = 1'b1; sel = 2;
    end else if (c == k + 68) begin
      b = 1'b1; ld = 1'b1; sel = 3; key = 0; msg = 1'b1;
    end else if (c >= k + 69) begin
      d = 1'b1;
    end
    return {b, d, kx, ld, 3'(sel), 2'(mw), 4'(key), msg};
  endfunction

  task automatic test_reset();
    logic [13:0] o;
    rst_n   = 1'b0;
    start_r = 3'b000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      n_checks++;
      if (o !== 14'd0) $display("FAIL reset_held inst%0d: got %h expected 0", i, o);
      else n_pass++;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      n_checks++;
      if (o !== 14'd0) $display("FAIL reset_idle inst%0d: got %h expected 0", i, o);
      else n_pass++;
    end
  endtask

  // Full run with Start held, then Start dropped; called at a negedge.
  task automatic test_nominal(input int idx, input int k);
    logic [13:0] o, e;
    int n_ld, n_kx, msg_cyc, n_msg, done_cyc, n_burst;
    int keys[$];
    bit key_ok;
    n_ld = 0; n_kx = 0; msg_cyc = -1; n_msg = 0; done_cyc = -1; n_burst = 0;
    start_r[idx] = 1'b1;
    for (int c = 1; c <= k + 75; c++) begin
      @(posedge clk); @(negedge clk);
      o = obs(idx);
      e = model(k, c);
      n_checks++;
      if (o !== e) $display("FAIL nominal_k%0d cycle %0d: got %h expected %h", k, c, o, e);
      else n_pass++;
      if (ld_w[idx]) n_ld++;
      if (kx_w[idx]) n_kx++;
      if (msg_w[idx]) begin n_msg++; msg_cyc = c; end
      if (done_w[idx] && done_cyc < 0) done_cyc = c;
      if (ld_w[idx] && sel_w[idx*3 +: 3] == 3'd3) keys.push_back(int'(key_w[idx*4 +: 4]));
      if (ld_w[idx] && sel_w[idx*3 +: 3] == 3'd4 && mix_w[idx*2 +: 2] == 2'd0) n_burst++;
    end
    n_checks++;
    if (n_ld !== 68) $display("FAIL ld_count_k%0d: got %0d expected 68", k, n_ld);
    else n_pass++;
    n_checks++;
    if (n_kx !== k) $display("FAIL keyexp_len_k%0d: got %0d expected %0d", k, n_kx, k);
    else n_pass++;
    n_checks++;
    if (n_msg !== 1 || msg_cyc !== k + 68)
      $display("FAIL msg_ld_k%0d: got %0d pulses last at %0d expected 1 at %0d", k, n_msg, msg_cyc, k + 68);
    else n_pass++;
    n_checks++;
    if (done_cyc !== k + 69) $display("FAIL done_first_k%0d: got %0d expected %0d", k, done_cyc, k + 69);
    else n_pass++;
    n_checks++;
    if (n_burst !== 9) $display("FAIL mix_bursts_k%0d: got %0d expected 9", k, n_burst);
    else n_pass++;
    key_ok = (keys.size() == 11);
    for (int i = 0; i < keys.size() && i < 11; i++) if (keys[i] != 10 - i) key_ok = 1'b0;
    n_checks++;
    if (!key_ok) $display("FAIL key_seq_k%0d: got %0d ark keys, sequence not 10..0", k, keys.size());
    else n_pass++;
    start_r[idx] = 1'b0;
    @(posedge clk); @(negedge clk);
    o = obs(idx);
    n_checks++;
    if (o !== 14'd0) $display("FAIL done_fall_k%0d: got %h expected 0", k, o);
    else n_pass++;
  endtask

  task automatic test_abort(input int idx, input int k, input int a);
    logic [13:0] o, e;
    start_r[idx] = 1'b1;
    for (int c = 1; c <= a; c++) begin
      @(posedge clk); @(negedge clk);
      o = obs(idx);
      e = model(k, c);
      n_checks++;
      if (o !== e) $display("FAIL abort_run_a%0d cycle %0d: got %h expected %h", a, c, o, e);
      else n_pass++;
    end
    start_r[idx] = 1'b0;
    for (int c = a + 1; c <= a + 6; c++) begin
      @(posedge clk); @(negedge clk);
      o = obs(idx);
      n_checks++;
      if (o !== 14'd0) $display("FAIL abort_idle_a%0d cycle %0d: got %h expected 0", a, c, o);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] o, e;
    start_r[0] = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      @(posedge clk); @(negedge clk);
      o = obs(0);
      e = model(12, c);
      n_checks++;
      if (o !== e) $display("FAIL rstmid_run cycle %0d: got %h expected %h", c, o, e);
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    o = obs(0);
    n_checks++;
    if (o !== 14'd0) $display("FAIL rstmid_async: got %h expected 0", o);
    else n_pass++;
    start_r[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_nominal(0, 12);
  endtask

  task automatic test_held_start();
    logic [13:0] o, e;
    start_r[0] = 1'b1;
    for (int c = 1; c <= 12 + 69 + 10; c++) begin
      @(posedge clk); @(negedge clk);
      o = obs(0);
      e = model(12, c);
      n_checks++;
      if (o !== e) $display("FAIL held_run cycle %0d: got %h expected %h", c, o, e);
      else n_pass++;
    end
    start_r[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    o = obs(0);
    n_checks++;
    if (o !== 14'd0) $display("FAIL held_drop: got %h expected 0", o);
    else n_pass++;
    start_r[0] = 1'b1;
    for (int c = 1; c <= 12 + 69; c++) begin
      @(posedge clk); @(negedge clk);
      o = obs(0);
      e = model(12, c);
      n_checks++;
      if (o !== e) $display("FAIL held_restart cycle %0d: got %h expected %h", c, o, e);
      else n_pass++;
    end
    start_r[0] = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal(0, 12);
    test_abort(0, 12, 40);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    test_abort(0, 12, int'($urandom_range(1, 79)));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    test_abort(2, 255, int'($urandom_range(1, 322)));
    test_reset_mid();
    test_held_start();
    test_nominal(1, 1);
    test_nominal(2, 255);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_controller.md
# aes_decrypt_controller

Sequencing FSM for the AES-128 decryption datapath behind the Avalon-MM AES register interface. It takes the Start register bit and steps the datapath through key-expansion wait, initial AddRoundKey, nine full inverse rounds and the final round. It drives per-cycle operation select, round-key index and InvMixColumns word select, then raises the Done register bit. It contains no datapath storage of its own.

## Interface
- KEYEXP_CYCLES, default 12: cycles reserved for key expansion; legal range 1..255.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- AES_START  in  1  Start register bit 0; level-sensitive.
- AES_DONE  out  1  Done register bit 0; high only in DONE.
- BUSY  out  1  high in every state except IDLE and DONE.
- KEYEXP_EN  out  1  key-expansion enable; high only in KEYEXP.
- STATE_LD  out  1  load enable for the 128-bit state register.
- STATE_SEL  out  3  state-register input mux: 0 = encrypted message, 1 = InvShiftRows, 2 = InvSubBytes, 3 = AddRoundKey, 4 = InvMixColumns word.
- MIX_WORD  out  2  32-bit column (0..3) written during INV_MIX.
- KEY_IDX  out  4  round-key index 0..10 used by AddRoundKey.
- MSG_DEC_LD  out  1  one-cycle strobe that captures the state register into decrypted-message registers 8-11.

## Operation
- States: IDLE, KEYEXP, LOAD, ARK_INIT, INV_SHIFT, INV_SUB, ARK, INV_MIX, F_SHIFT, F_SUB, F_ARK, DONE.
- Internal counters:
  - wait counter, 8 bits;
  - round counter rnd, 4 bits, range 9 down to 1;
  - word counter, 2 bits, drives MIX_WORD.
- IDLE: when AES_START = 1, go to KEYEXP and load the wait counter with KEYEXP_CYCLES-1.
- KEYEXP: decrement the wait counter; go to LOAD on the cycle the counter is 0.
- LOAD: STATE_SEL = 0, STATE_LD = 1.
- ARK_INIT: STATE_SEL = 3, KEY_IDX = 10, STATE_LD = 1; set rnd = 9.
- Full rounds:
  - INV_SHIFT: STATE_SEL = 1, STATE_LD = 1.
  - INV_SUB: STATE_SEL = 2, STATE_LD = 1.
  - ARK: STATE_SEL = 3, KEY_IDX = rnd, STATE_LD = 1.
  - INV_MIX: STATE_SEL = 4, STATE_LD = 1, MIX_WORD = word counter; stays 4 cycles (word 0..3).
  - After word 3: if rnd = 1 go to F_SHIFT; otherwise decrement rnd and go to INV_SHIFT.
- Final round:
  - F_SHIFT: STATE_SEL = 1, STATE_LD = 1.
  - F_SUB: STATE_SEL = 2, STATE_LD = 1.
  - F_ARK: STATE_SEL = 3, KEY_IDX = 0, STATE_LD = 1, MSG_DEC_LD = 1. The datapath captures the ARK result, so MSG_DEC_LD must select the post-ARK value.
- DONE: AES_DONE = 1; remain until AES_START = 0, then go to IDLE.
- Abort: AES_START = 0 in any BUSY state forces IDLE on the next edge. No MSG_DEC_LD is issued and registers 8-11 keep their old contents.
- Idle outputs: all load strobes are 0 outside the states listed above. STATE_SEL, KEY_IDX and MIX_WORD are 0 whenever their strobe is 0.
- Output decoding: all outputs are Moore functions of state and counters. No output depends combinationally on AES_START.

## Timing
- Reset: RESET low → IDLE and all counters 0. Every output is 0 while reset is held and in IDLE.
- Reset mid-operation: aborts immediately and asynchronously; no partial MSG_DEC_LD.
- Cycle numbering: edge 0 is the first edge sampling AES_START = 1 in IDLE.
  - KEYEXP: cycles 1..K, where K = KEYEXP_CYCLES.
  - LOAD: cycle K+1.
  - ARK_INIT: cycle K+2.
  - Rounds 9..1: cycles K+3..K+65, 7 cycles per round.
  - F_SHIFT, F_SUB, F_ARK: cycles K+66, K+67, K+68.
  - AES_DONE first high in cycle K+69 (81 with the default K).
- STATE_LD pulses: 1 + 1 + 63 + 3 = 68 per decryption.
- Restart: AES_START held high through DONE does not restart the sequence. AES_START must be low for at least 1 cycle (return to IDLE) before it is accepted again.
- AES_DONE falls on the edge after AES_START is sampled low.

## Structure
- Shared package aes_ctrl_pkg holds:
  - the FSM state enum;
  - STATE_SEL encodings SEL_MSG, SEL_ISR, SEL_ISB, SEL_ARK, SEL_IMC;
  - NUM_ROUNDS = 10.
- Single module with no sub-modules; the three counters live inline with the FSM.
- The Avalon interface maps Start register 14 bit 0 to AES_START and AES_DONE to Done register 15 bit 0.

## Test plan
- Nominal run: K = 12, reset then AES_START = 1 and held. Required:
  - exactly 68 STATE_LD pulses;
  - KEY_IDX sequence 10, 9, 8, …, 1, 0 on ARK cycles;
  - MSG_DEC_LD only in cycle 80;
  - AES_DONE high from cycle 81.
- MIX_WORD order: each INV_MIX burst shows MIX_WORD 0, 1, 2, 3 on consecutive cycles with STATE_SEL = 4; there are 9 bursts.
- Abort: drop AES_START in cycle 40. Required: IDLE at cycle 41, BUSY = 0, no MSG_DEC_LD, all strobes 0.
- Reset mid-operation: assert RESET low in cycle 55. Required: all outputs 0 immediately without waiting for CLK; after release, a fresh start completes in 81 cycles.
- Held start: AES_START held high 10 cycles past DONE. Required: AES_DONE stays 1 and no restart. Then drop AES_START for 1 cycle and raise it again. Required: AES_DONE falls and a new run begins.
- Parameter sweep: KEYEXP_CYCLES = 1 and 255. Required: AES_DONE first high at cycles 70 and 324; KEYEXP_EN high for exactly K cycles.
